// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared widths, fault codes and FSM encoding for the divider front-end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DEND_W_DEF = 13;
    localparam int DSOR_W_DEF = 6;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_DIV0 = 2'b01;
    localparam logic [1:0] FAULT_OVF  = 2'b10;
    localparam logic [1:0] FAULT_TMO  = 2'b11;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] CHECK = 2'b01;
    localparam logic [1:0] WAIT  = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/op_fifo.sv
// ============================================================================
// Module   : op_fifo
// Purpose  : Synchronous FIFO holding packed {dividend, divisor} requests.
// Revision : 1.0
// ============================================================================
`default_nettype none

module op_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_operand_dispatch.sv
// ============================================================================
// Module   : div_operand_dispatch
// Purpose  : Queues divide requests, screens div-by-zero/overflow, issues to divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_operand_dispatch
    import div_pkg::*;
#(
    parameter int DEND_W  = DEND_W_DEF,
    parameter int DSOR_W  = DSOR_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DEND_W-1:0] in_dividend,
    input  logic [DSOR_W-1:0] in_divisor,
    output logic              div_start,
    output logic [DEND_W-1:0] div_dividend,
    output logic [DSOR_W-1:0] div_divisor,
    output logic [1:0]        div_tag,
    input  logic              div_done,
    output logic              fault_valid,
    output logic [1:0]        fault_code,
    output logic              busy
);

    localparam int CMP_W = max_int(DEND_W - DSOR_W, DSOR_W);
    localparam int TMO_W = $clog2(TIMEOUT);

    logic [1:0]               state_q, state_d;
    logic [DEND_W-1:0]        dend_q;
    logic [DSOR_W-1:0]        dsor_q;
    logic [1:0]               tag_q;
    logic [1:0]               tag_cnt_q;
    logic [TMO_W-1:0]         tmo_q;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic [DEND_W+DSOR_W-1:0] head;
    logic                     div0;
    logic                     ovf;
    logic                     tmo_hit;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && !fifo_empty;
    assign busy     = (state_q != IDLE) || !fifo_empty;

    op_fifo #(
        .WIDTH (DEND_W + DSOR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_dividend, in_divisor}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (head)
    );

    // Quotient fits in DSOR_W bits only when the high dividend part is below the divisor.
    assign div0    = (dsor_q == '0);
    assign ovf     = (CMP_W'(dend_q[DEND_W-1:DSOR_W]) >= CMP_W'(dsor_q));
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = CHECK;
            CHECK:   state_d = (div0 || ovf) ? IDLE : WAIT;
            WAIT:    if (div_done || tmo_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dend_q    <= '0;
            dsor_q    <= '0;
            tag_q     <= '0;
            tag_cnt_q <= '0;
            tmo_q     <= '0;
        end else begin
            if (pop) begin
                dend_q    <= head[DEND_W+DSOR_W-1:DSOR_W];
                dsor_q    <= head[DSOR_W-1:0];
                tag_q     <= tag_cnt_q;
                tag_cnt_q <= tag_cnt_q + 2'd1;
            end
            if (state_q == CHECK) begin
                tmo_q <= '0;
            end else if (state_q == WAIT && !div_done) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end

    always_comb begin
        div_start   = 1'b0;
        fault_valid = 1'b0;
        fault_code  = FAULT_NONE;
        case (state_q)
            CHECK: begin
                if (div0) begin
                    fault_valid = 1'b1;
                    fault_code  = FAULT_DIV0;
                end else if (ovf) begin
                    fault_valid = 1'b1;
                    fault_code  = FAULT_OVF;
                end else begin
                    div_start = 1'b1;
                end
            end
            WAIT: begin
                if (!div_done && tmo_hit) begin
                    fault_valid = 1'b1;
                    fault_code  = FAULT_TMO;
                end
            end
            default: ;
        endcase
    end

    assign div_dividend = dend_q;
    assign div_divisor  = dsor_q;
    assign div_tag      = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_div_operand_dispatch.sv
// ============================================================================
// Module   : tb_div_operand_dispatch
// Purpose  : Directed self-checking bench for div_operand_dispatch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_operand_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_dividend = '0;
    logic [5:0]  in_divisor = '0;
    logic        div_start;
    logic [12:0] div_dividend;
    logic [5:0]  div_divisor;
    logic [1:0]  div_tag;
    logic        div_done = 1'b0;
    logic        fault_valid;
    logic [1:0]  fault_code;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_operand_dispatch #(
        .DEND_W (13),
        .DSOR_W (6),
        .DEPTH  (4),
        .TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_tag      (div_tag),
        .div_done     (div_done),
        .fault_valid  (fault_valid),
        .fault_code   (fault_code),
        .busy         (busy)
    );

    // Advance to just after the next rising edge: inputs driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        div_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b want 0", div_start); end
        checks++; if (fault_valid !== 1'b0) begin errors++; $display("FAIL reset_fault_valid got %0b want 0", fault_valid); end
        checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL reset_fault_code got %0d want 0", fault_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if ({div_dividend, div_divisor, div_tag} !== 21'd0) begin errors++; $display("FAIL reset_operands got %0h/%0h/%0d want 0", div_dividend, div_divisor, div_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_issue();
        do_reset();
        in_valid = 1'b1; in_dividend = 13'd100; in_divisor = 6'd7;
        tick();
        in_valid = 1'b0;
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL issue_early_start got %0b want 0", div_start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL issue_busy_n1 got %0b want 1", busy); end
        tick();
        checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL issue_start got %0b want 1", div_start); end
        checks++; if (div_dividend !== 13'd100 || div_divisor !== 6'd7 || div_tag !== 2'd0) begin errors++; $display("FAIL issue_operands got %0d/%0d/%0d want 100/7/0", div_dividend, div_divisor, div_tag); end
        checks++; if (fault_valid !== 1'b0) begin errors++; $display("FAIL issue_fault got %0b want 0", fault_valid); end
        tick();
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL issue_start_pulse got %0b want 0", div_start); end
        tick(); tick(); tick();
        div_done = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL issue_busy_wait got %0b want 1", busy); end
        tick();
        div_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL issue_busy_after_done got %0b want 0", busy); end
        checks++; if (div_dividend !== 13'd100) begin errors++; $display("FAIL issue_hold got %0d want 100", div_dividend); end
    endtask

    task automatic test_div0();
        do_reset();
        in_valid = 1'b1; in_dividend = 13'd50; in_divisor = 6'd0;
        tick();
        in_valid = 1'b0;
        checks++; if (div_start !== 1'b0 || fault_valid !== 1'b0) begin errors++; $display("FAIL div0_n1 got start=%0b fault=%0b want 0/0", div_start, fault_valid); end
        tick();
        checks++; if (fault_valid !== 1'b1 || fault_code !== 2'b01) begin errors++; $display("FAIL div0_fault got %0b/%0d want 1/1", fault_valid, fault_code); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL div0_no_start got %0b want 0", div_start); end
        tick();
        checks++; if (fault_valid !== 1'b0 || fault_code !== 2'b00 || busy !== 1'b0 || div_start !== 1'b0) begin errors++; $display("FAIL div0_after got fv=%0b fc=%0d busy=%0b st=%0b want 0/0/0/0", fault_valid, fault_code, busy, div_start); end
        in_valid = 1'b1; in_dividend = 13'd100; in_divisor = 6'd7;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (div_start !== 1'b1 || div_tag !== 2'd1) begin errors++; $display("FAIL div0_next_tag got start=%0b tag=%0d want 1/1", div_start, div_tag); end
        tick();
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        in_valid = 1'b1; in_dividend = 13'h1FC0; in_divisor = 6'd5;
        tick();
        in_dividend = 13'd448; in_divisor = 6'd7;
        tick();
        in_dividend = 13'd447; in_divisor = 6'd7;
        checks++; if (fault_valid !== 1'b1 || fault_code !== 2'b10 || div_start !== 1'b0) begin errors++; $display("FAIL ovf_big got fv=%0b fc=%0d st=%0b want 1/2/0", fault_valid, fault_code, div_start); end
        tick();
        in_valid = 1'b0;
        checks++; if (fault_valid !== 1'b0) begin errors++; $display("FAIL ovf_gap got %0b want 0", fault_valid); end
        tick();
        checks++; if (fault_valid !== 1'b1 || fault_code !== 2'b10 || div_tag !== 2'd1) begin errors++; $display("FAIL ovf_equal got fv=%0b fc=%0d tag=%0d want 1/2/1", fault_valid, fault_code, div_tag); end
        tick();
        tick();
        checks++; if (div_start !== 1'b1 || div_dividend !== 13'd447 || div_tag !== 2'd2 || fault_valid !== 1'b0) begin errors++; $display("FAIL ovf_ok got st=%0b dend=%0d tag=%0d fv=%0b want 1/447/2/0", div_start, div_dividend, div_tag, fault_valid); end
        tick();
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_idle got %0b want 0", busy); end
    endtask

    task automatic test_timeout();
        do_reset();
        in_valid = 1'b1; in_dividend = 13'd100; in_divisor = 6'd7;
        tick();
        in_dividend = 13'd200; in_divisor = 6'd9;
        tick();
        in_valid = 1'b0;
        checks++; if (div_start !== 1'b1 || div_tag !== 2'd0) begin errors++; $display("FAIL tmo_start got %0b/%0d want 1/0", div_start, div_tag); end
        for (int i = 0; i < 15; i++) tick();
        checks++; if (fault_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early got fv=%0b busy=%0b want 0/1", fault_valid, busy); end
        tick();
        checks++; if (fault_valid !== 1'b1 || fault_code !== 2'b11 || div_tag !== 2'd0) begin errors++; $display("FAIL tmo_fault got fv=%0b fc=%0d tag=%0d want 1/3/0", fault_valid, fault_code, div_tag); end
        tick();
        checks++; if (fault_valid !== 1'b0 || div_start !== 1'b0) begin errors++; $display("FAIL tmo_idle got fv=%0b st=%0b want 0/0", fault_valid, div_start); end
        tick();
        checks++; if (div_start !== 1'b1 || div_tag !== 2'd1 || div_dividend !== 13'd200 || div_divisor !== 6'd9) begin errors++; $display("FAIL tmo_next got st=%0b tag=%0d op=%0d/%0d want 1/1/200/9", div_start, div_tag, div_dividend, div_divisor); end
        tick();
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_drain got %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_dend [5];
        logic [1:0]  exp_tag  [5];
        exp_dend[0] = 13'd10; exp_dend[1] = 13'd20; exp_dend[2] = 13'd30; exp_dend[3] = 13'd40; exp_dend[4] = 13'd50;
        exp_tag[0] = 2'd1; exp_tag[1] = 2'd2; exp_tag[2] = 2'd3; exp_tag[3] = 2'd0; exp_tag[4] = 2'd1;
        do_reset();
        in_valid = 1'b1; in_dividend = 13'd100; in_divisor = 6'd7;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_dividend = exp_dend[i]; in_divisor = 6'd3;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %0b want 1", i, in_ready); end
            tick();
        end
        in_dividend = exp_dend[4];
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %0b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0 || div_start !== 1'b0) begin errors++; $display("FAIL b2b_hold got rdy=%0b st=%0b want 0/0", in_ready, div_start); end
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_pop_cycle got %0b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got %0b want 1", in_ready); end
        checks++; if (div_start !== 1'b1 || div_dividend !== exp_dend[0] || div_tag !== exp_tag[0]) begin errors++; $display("FAIL b2b_issue_0 got st=%0b dend=%0d tag=%0d want 1/%0d/%0d", div_start, div_dividend, div_tag, exp_dend[0], exp_tag[0]); end
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_refill got %0b want 0", in_ready); end
        for (int k = 1; k < 5; k++) begin
            div_done = 1'b1;
            tick();
            div_done = 1'b0;
            tick();
            checks++; if (div_start !== 1'b1 || div_dividend !== exp_dend[k] || div_tag !== exp_tag[k]) begin errors++; $display("FAIL b2b_issue_%0d got st=%0b dend=%0d tag=%0d want 1/%0d/%0d", k, div_start, div_dividend, div_tag, exp_dend[k], exp_tag[k]); end
            tick();
        end
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_end got busy=%0b rdy=%0b want 0/1", busy, in_ready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; in_dividend = 13'd100; in_divisor = 6'd7;
        tick();
        in_dividend = 13'd60; in_divisor = 6'd4;
        tick();
        in_dividend = 13'd70; in_divisor = 6'd5;
        tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || div_start !== 1'b0) begin errors++; $display("FAIL rstmid_wait got busy=%0b st=%0b want 1/0", busy, div_start); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || div_tag !== 2'd0) begin errors++; $display("FAIL rstmid_after got busy=%0b rdy=%0b tag=%0d want 0/1/0", busy, in_ready, div_tag); end
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (div_start !== 1'b0 || busy !== 1'b0 || fault_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet_%0d got st=%0b busy=%0b fv=%0b want 0/0/0", i, div_start, busy, fault_valid); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_div0();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/div_operand_dispatch.md
Name: div_operand_dispatch

Overview:
Upstream front-end for the restoring divider datapath/controller pair. Accepts dividend/divisor requests over a valid/ready handshake and buffers them in a small FIFO. Screens each request for divide-by-zero and quotient overflow, then issues clean operands to the divider with a one-cycle start pulse and waits for its done. Screened-out requests and divider timeouts are reported on a fault port and never reach the divider.

Parameters:
DEND_W, 13, dividend width
DSOR_W, 6, divisor width; quotient width equals DSOR_W
DEPTH, 4, FIFO entries; power of two, at least 2
TIMEOUT, 16, max cycles in WAIT before timeout fault; at least 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_dividend  input  DEND_W  dividend
in_divisor  input  DSOR_W  divisor
div_start  output  1  one-cycle start pulse to divider controller
div_dividend  output  DEND_W  operand, held stable from start until done
div_divisor  output  DSOR_W  operand, held stable from start until done
div_tag  output  2  sequence tag of issued or faulted request
div_done  input  1  divider completion pulse
fault_valid  output  1  one-cycle fault pulse
fault_code  output  2  01 div-by-zero, 10 overflow, 11 timeout; 00 when no fault
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset: FIFO empty, state IDLE, tag counter 0. div_start, fault_valid and busy are 0. fault_code, div_dividend, div_divisor and div_tag are 0. in_ready is 1 in the cycle after reset deasserts.
- in_ready = !full, combinational from the registered count. A pop in the same cycle does not raise in_ready when full.
- Push and pop in the same cycle are allowed when not full; the count is unchanged.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- FSM states: IDLE, CHECK, WAIT.
  - IDLE: if FIFO is non-empty, pop the head into the operand registers, latch tag = tag counter, increment the tag counter (wraps 3 to 0), go to CHECK.
  - CHECK, first match wins:
    - divisor == 0: fault_valid=1, fault_code=01, go to IDLE.
    - dividend[DEND_W-1:DSOR_W] >= divisor (unsigned): fault_valid=1, fault_code=10, go to IDLE.
    - otherwise: div_start=1, clear timeout counter, go to WAIT.
  - WAIT: on div_done, go to IDLE. Otherwise increment the timeout counter; when it reaches TIMEOUT-1 without done: fault_valid=1, fault_code=11, go to IDLE.
- div_done outside WAIT is ignored.
- Latency: a request accepted in cycle N with the FIFO empty and state IDLE produces div_start or fault_valid in cycle N+2. Back-to-back issue: the next start comes no earlier than 2 cycles after the done cycle.
- Operand and tag outputs are registered and change only on a pop in IDLE.
- Reset mid-operation: queued entries are discarded, the FSM returns to IDLE and no further start is issued. The divider is cleared by the same rst.
- Overflow comparison is zero-extended to max(DEND_W-DSOR_W, DSOR_W) bits.

Decomposition:
- Shared package div_pkg holds:
  - DEND_W and DSOR_W defaults
  - fault code constants FAULT_NONE, FAULT_DIV0, FAULT_OVF, FAULT_TMO
  - state encoding IDLE=2'b00, CHECK=2'b01, WAIT=2'b10
- One sub-module: op_fifo, a synchronous FIFO with width DEND_W+DSOR_W and DEPTH entries, exposing push, pop, full, empty and the head word. Screening, the FSM and the timeout counter stay in the top level.

Test Plan:
- Push dividend=100, divisor=7 at cycle N, idle and empty -> div_start at N+2 with div_dividend=100, div_divisor=7, div_tag=0; div_done at N+6 -> busy=0 at N+7.
- Push divisor=0, dividend=50 -> fault_valid at N+2 with fault_code=01; div_start never asserts; next request gets tag 1.
- Push dividend=13'h1FC0, divisor=5 (upper 127 >= 5) -> fault_code=10. Push dividend=447, divisor=7 (upper 6 < 7) -> issued normally.
- Hold div_done low and push 5 requests while WAIT is stalled -> first issued, next 4 fill the FIFO (in_ready=0 in the cycle after the 4th queued push, so the 5th is refused), 5th held off; done releases one entry per issue, in_ready returns to 1.
- TIMEOUT=16, no div_done -> fault_code=11 after 16 WAIT cycles, FSM back in IDLE, next queued request issues 2 cycles later.
- rst asserted in WAIT with 2 entries queued -> next cycle busy=0, in_ready=1, tag=0; late div_done ignored and no start issued.
